// File: rtl/pipelined_decoder.sv
// Registered, handshaked opcode decoder: classifies the opcode and looks up a
// programmable control word, with a one-entry output stage and a HALT/resume FSM.
module pipelined_decoder #(
  parameter int IW    = 8,
  parameter int OW    = 10,
  parameter int NCLS  = 8,
  parameter int CNT_W = 16,
  localparam int AW   = $clog2(NCLS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IW-1:0]    instruction,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OW-1:0]    control_signals,
  output logic             special_reg,
  output logic             temp_mem,
  output logic [2:0]       cls,
  output logic             halted,
  input  logic             resume,
  input  logic             cfg_we,
  input  logic [AW-1:0]    cfg_addr,
  input  logic [OW-1:0]    cfg_data,
  output logic [CNT_W-1:0] decode_count
);

  typedef enum logic [0:0] {RUN = 1'b0, HALTED = 1'b1} state_t;

  // Returns {is_halt, temp_mem, cls}; first matching pattern wins.
  function automatic logic [4:0] classify(input logic [7:0] op);
    logic [4:0] res;
    casez (op)
      8'b0111_0000: res = {1'b1, 1'b0, 3'd6};
      8'b10??_????: res = {1'b0, 1'b0, 3'd0};
      8'b110?_????: res = {1'b0, 1'b0, 3'd1};
      8'b111?_????: res = {1'b0, 1'b0, 3'd2};
      8'b0110_1???: res = {1'b0, 1'b0, 3'd4};
      8'b0110_0???: res = {1'b0, 1'b0, 3'd5};
      8'b0111_110?: res = {1'b0, 1'b1, 3'd4};
      8'b0111_11??: res = {1'b0, 1'b1, 3'd5};
      default:      res = {1'b0, 1'b0, 3'd3};
    endcase
    return res;
  endfunction

  state_t            state_r, state_next_s;
  logic [OW-1:0]     table_r [NCLS];
  logic              out_valid_r, special_reg_r, temp_mem_r;
  logic [OW-1:0]     control_r;
  logic [2:0]        cls_r;
  logic [CNT_W-1:0]  count_r;
  logic [4:0]        class_s;
  logic              accept_s, cfg_ok_s;
  logic [OW-1:0]     word_s;

  assign class_s  = classify(instruction[IW-1:IW-8]);
  assign word_s   = table_r[AW'(class_s[2:0])];
  assign in_ready = (state_r == RUN) && (!out_valid_r || out_ready);
  assign accept_s = in_valid && in_ready;

  generate
    if ((1 << AW) == NCLS) begin : g_full_addr
      assign cfg_ok_s = 1'b1;
    end else begin : g_part_addr
      assign cfg_ok_s = (cfg_addr < AW'(NCLS));
    end
  endgenerate

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= RUN;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state: halt on accepted HALT, leave on resume
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      RUN: begin
        if (accept_s && class_s[4]) begin
          state_next_s = HALTED;
        end else begin
          state_next_s = RUN;
        end
      end
      HALTED: begin
        if (resume) begin
          state_next_s = RUN;
        end else begin
          state_next_s = HALTED;
        end
      end
      default: state_next_s = RUN;
    endcase
  end

  // Control table: writes take effect after the edge, so a same-cycle accept sees the old word
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NCLS; i++) begin
        table_r[i] <= {OW{1'b0}};
      end
    end else if (cfg_we && cfg_ok_s) begin
      table_r[cfg_addr] <= cfg_data;
    end
  end

  // Output stage and saturating retire counter
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_r   <= 1'b0;
      control_r     <= {OW{1'b0}};
      special_reg_r <= 1'b0;
      temp_mem_r    <= 1'b0;
      cls_r         <= 3'd0;
      count_r       <= {CNT_W{1'b0}};
    end else begin
      if (accept_s) begin
        out_valid_r   <= 1'b1;
        control_r     <= word_s;
        special_reg_r <= ~word_s[6] & word_s[3];
        temp_mem_r    <= class_s[3];
        cls_r         <= class_s[2:0];
      end else if (out_ready) begin
        out_valid_r   <= 1'b0;
      end
      if (accept_s && (count_r != {CNT_W{1'b1}})) begin
        count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign out_valid       = out_valid_r;
  assign control_signals = control_r;
  assign special_reg     = special_reg_r;
  assign temp_mem        = temp_mem_r;
  assign cls             = cls_r;
  assign halted          = (state_r == HALTED);
  assign decode_count    = count_r;

endmodule

// File: tb/tb_pipelined_decoder.sv
// Directed self-checking bench for pipelined_decoder with hand-computed expectations.
module tb_pipelined_decoder;

  logic        clk = 1'b0;
  logic        reset, in_valid, in_ready, out_valid, out_ready;
  logic [7:0]  instruction;
  logic [9:0]  control_signals;
  logic        special_reg, temp_mem, halted, resume, cfg_we;
  logic [2:0]  cls, cfg_addr;
  logic [9:0]  cfg_data;
  logic [15:0] decode_count;

  int compared_cnt = 0;
  int mismatch_cnt = 0;

  pipelined_decoder dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .instruction(instruction), .out_valid(out_valid), .out_ready(out_ready),
    .control_signals(control_signals), .special_reg(special_reg),
    .temp_mem(temp_mem), .cls(cls), .halted(halted), .resume(resume),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .decode_count(decode_count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared_cnt++;
    if (got !== exp) begin
      mismatch_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_tbl(input logic [2:0] addr, input logic [9:0] data);
    cfg_we = 1'b1; cfg_addr = addr; cfg_data = data;
    tick();
    cfg_we = 1'b0;
  endtask

  // One accept with out_ready=1; afterwards the output holds its result
  task automatic send(input logic [7:0] instr);
    in_valid = 1'b1; instruction = instr; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  logic [7:0] s_op  [8] = '{8'h80, 8'hC0, 8'hE0, 8'h00, 8'h68, 8'h60, 8'h7C, 8'h7E};
  logic [2:0] s_cls [8] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd4, 3'd5};
  logic [9:0] s_cw  [8] = '{10'd1, 10'd2, 10'd3, 10'd4, 10'd5, 10'd6, 10'd5, 10'd6};
  logic       s_tm  [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

  // Edge-case opcodes; table[3] is 0x008 when these run
  logic [7:0] e_op  [8] = '{8'h71, 8'h77, 8'h7D, 8'h7F, 8'hBF, 8'hDF, 8'h6F, 8'h3F};
  logic [2:0] e_cls [8] = '{3'd3, 3'd3, 3'd4, 3'd5, 3'd0, 3'd1, 3'd4, 3'd3};
  logic       e_tm  [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
  logic [9:0] e_cw  [8] = '{10'h008, 10'h008, 10'd5, 10'd6, 10'd1, 10'd2, 10'd5, 10'h008};

  initial begin
    reset = 1'b1; in_valid = 1'b0; instruction = 8'h00; out_ready = 1'b0;
    resume = 1'b0; cfg_we = 1'b0; cfg_addr = 3'd0; cfg_data = 10'd0;
    tick(); tick();
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_halted", 32'(halted), 32'd0);
    check_eq("rst_count", 32'(decode_count), 32'd0);
    check_eq("rst_ctrl", 32'(control_signals), 32'd0);
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);
    reset = 1'b0;

    for (int i = 0; i < 7; i++) write_tbl(3'(i), 10'(i + 1));

    // Streaming at full throughput
    in_valid = 1'b1; out_ready = 1'b1; instruction = s_op[0];
    for (int k = 0; k < 8; k++) begin
      tick();
      check_eq($sformatf("stream_cls%0d", k), 32'(cls), 32'(s_cls[k]));
      check_eq($sformatf("stream_cw%0d", k), 32'(control_signals), 32'(s_cw[k]));
      check_eq($sformatf("stream_tm%0d", k), 32'(temp_mem), 32'(s_tm[k]));
      check_eq($sformatf("stream_ov%0d", k), 32'(out_valid), 32'd1);
      if (k < 7) instruction = s_op[k + 1];
      else in_valid = 1'b0;
    end
    check_eq("stream_count", 32'(decode_count), 32'd8);
    tick();
    check_eq("stream_drain", 32'(out_valid), 32'd0);

    // Backpressure
    in_valid = 1'b1; instruction = 8'h80;
    tick();
    out_ready = 1'b0; instruction = 8'hC0;
    #1;
    check_eq("bp_in_ready0", 32'(in_ready), 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check_eq($sformatf("bp_ov%0d", k), 32'(out_valid), 32'd1);
      check_eq($sformatf("bp_cls%0d", k), 32'(cls), 32'd0);
      check_eq($sformatf("bp_cw%0d", k), 32'(control_signals), 32'd1);
      check_eq($sformatf("bp_in_ready%0d", k), 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    #1;
    check_eq("bp_release_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    check_eq("bp_next_cls", 32'(cls), 32'd1);
    check_eq("bp_next_cw", 32'(control_signals), 32'd2);
    check_eq("bp_next_ov", 32'(out_valid), 32'd1);
    tick();
    check_eq("bp_no_dup", 32'(out_valid), 32'd0);
    check_eq("bp_count", 32'(decode_count), 32'd10);

    // HALT and resume
    in_valid = 1'b1; instruction = 8'h00;
    tick();
    check_eq("halt_r0_cls", 32'(cls), 32'd3);
    check_eq("halt_r0_halted", 32'(halted), 32'd0);
    instruction = 8'h70;
    tick();
    check_eq("halt_cls", 32'(cls), 32'd6);
    check_eq("halt_cw", 32'(control_signals), 32'd7);
    check_eq("halt_halted", 32'(halted), 32'd1);
    instruction = 8'h00;
    #1;
    check_eq("halt_in_ready", 32'(in_ready), 32'd0);
    tick();
    check_eq("halt_drain", 32'(out_valid), 32'd0);
    check_eq("halt_count", 32'(decode_count), 32'd12);
    tick();
    check_eq("halt_hold", 32'(halted), 32'd1);
    resume = 1'b1;
    #1;
    check_eq("resume_cycle_ready", 32'(in_ready), 32'd0);
    tick();
    resume = 1'b0;
    check_eq("resume_halted", 32'(halted), 32'd0);
    check_eq("resume_count", 32'(decode_count), 32'd12);
    check_eq("resume_in_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    check_eq("resume_accept_cls", 32'(cls), 32'd3);
    check_eq("resume_accept_count", 32'(decode_count), 32'd13);
    tick();

    // special_reg derivation
    write_tbl(3'd3, 10'b00_0000_1000);
    send(8'h00);
    check_eq("special_set", 32'(special_reg), 32'd1);
    check_eq("special_set_cw", 32'(control_signals), 32'h008);

    // Classification corner opcodes
    for (int k = 0; k < 8; k++) begin
      send(e_op[k]);
      check_eq($sformatf("edge_cls_%0h", e_op[k]), 32'(cls), 32'(e_cls[k]));
      check_eq($sformatf("edge_tm_%0h", e_op[k]), 32'(temp_mem), 32'(e_tm[k]));
      check_eq($sformatf("edge_cw_%0h", e_op[k]), 32'(control_signals), 32'(e_cw[k]));
    end

    write_tbl(3'd3, 10'b00_0100_1000);
    send(8'h00);
    check_eq("special_clr", 32'(special_reg), 32'd0);

    // Table write colliding with accept uses the old entry
    cfg_we = 1'b1; cfg_addr = 3'd3; cfg_data = 10'h155;
    in_valid = 1'b1; instruction = 8'h00; out_ready = 1'b1;
    tick();
    cfg_we = 1'b0; in_valid = 1'b0;
    check_eq("collide_old", 32'(control_signals), 32'h048);
    send(8'h00);
    check_eq("collide_new", 32'(control_signals), 32'h155);
    check_eq("collide_special", 32'(special_reg), 32'd0);
    tick();

    // Reset while HALTED with a held output
    out_ready = 1'b0; in_valid = 1'b1; instruction = 8'h70;
    tick();
    in_valid = 1'b0;
    check_eq("prerst_ov", 32'(out_valid), 32'd1);
    check_eq("prerst_halted", 32'(halted), 32'd1);
    reset = 1'b1;
    tick();
    check_eq("midrst_ov", 32'(out_valid), 32'd0);
    check_eq("midrst_halted", 32'(halted), 32'd0);
    check_eq("midrst_count", 32'(decode_count), 32'd0);
    check_eq("midrst_in_ready", 32'(in_ready), 32'd1);
    reset = 1'b0;
    send(8'hE0);
    check_eq("postrst_cls", 32'(cls), 32'd2);
    check_eq("postrst_tbl2", 32'(control_signals), 32'd0);
    send(8'h7E);
    check_eq("postrst_tbl5", 32'(control_signals), 32'd0);
    check_eq("postrst_count", 32'(decode_count), 32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared_cnt, mismatch_cnt);
    $finish;
  end

endmodule
